// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues item/nickel/dime jobs and fires one solenoid per job until its sensor confirms.
// Request at edge t fires from cycle t+2 when idle; no backpressure, a request with no free slot is dropped and sets overflow.
module vend_dispense_ctrl #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int QDEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vend_in,
  input  logic                     change_5c_in,
  input  logic                     change_10c_in,
  input  logic                     item_sense,
  input  logic                     coin_sense,
  input  logic                     clear_fault,
  output logic                     item_sol,
  output logic                     coin5_sol,
  output logic                     coin10_sol,
  output logic                     busy,
  output logic                     fault,
  output logic [1:0]               fault_job,
  output logic                     overflow,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(PULSE_CYC + GAP_CYC + TIMEOUT_CYC + 1);

  localparam logic [1:0] JOB_ITEM = 2'b01;
  localparam logic [1:0] JOB_N5   = 2'b10;
  localparam logic [1:0] JOB_D10  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_FIRE, S_WAIT, S_GAP, S_FAULT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      job_q, job_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            conf_q, conf_d;
  logic [2:0]      sol_q, sol_d;
  logic            ovf_q, ovf_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]      mem_q [QDEPTH];

  logic            pop;
  logic [AW:0]     free_slots;
  logic            acc_item, acc_dime, acc_nick;
  logic [AW-1:0]   p_dime, p_nick;
  logic            sense_ok;

  // A pop this cycle frees its slot before any of this cycle's writes are considered.
  always_comb begin
    pop        = (state_q == S_IDLE) && (count_q != '0);
    free_slots = (AW+1)'(QDEPTH) - count_q + (AW+1)'(pop);
    acc_item   = vend_in && (free_slots != '0);
    acc_dime   = change_10c_in && (free_slots > (AW+1)'(acc_item));
    acc_nick   = change_5c_in &&
                 (free_slots > ((AW+1)'(acc_item) + (AW+1)'(acc_dime)));
    p_dime     = wr_ptr_q + AW'(acc_item);
    p_nick     = p_dime + AW'(acc_dime);
    wr_ptr_d   = p_nick + AW'(acc_nick);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q - (AW+1)'(pop) + (AW+1)'(acc_item)
               + (AW+1)'(acc_dime) + (AW+1)'(acc_nick);
    ovf_d      = ovf_q | (vend_in & ~acc_item) | (change_10c_in & ~acc_dime)
               | (change_5c_in & ~acc_nick);
  end

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    cnt_d    = cnt_q;
    conf_d   = conf_q;
    sense_ok = (job_q == JOB_ITEM) ? item_sense : coin_sense;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_FIRE;
          job_d   = mem_q[rd_ptr_q];
          cnt_d   = '0;
          conf_d  = 1'b0;
        end
      end
      S_FIRE: begin
        if (sense_ok) conf_d = 1'b1;
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (conf_q || sense_ok) ? S_GAP : S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (sense_ok) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FAULT: begin
        if (clear_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Solenoids are decoded from next state so they toggle exactly on state entry/exit.
    sol_d = 3'b000;
    if (state_d == S_FIRE) begin
      case (job_d)
        JOB_ITEM: sol_d = 3'b100;
        JOB_N5:   sol_d = 3'b010;
        JOB_D10:  sol_d = 3'b001;
        default:  sol_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      job_q    <= 2'b00;
      cnt_q    <= '0;
      conf_q   <= 1'b0;
      sol_q    <= 3'b000;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      cnt_q    <= cnt_d;
      conf_q   <= conf_d;
      sol_q    <= sol_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_item) mem_q[wr_ptr_q] <= JOB_ITEM;
    if (acc_dime) mem_q[p_dime]   <= JOB_D10;
    if (acc_nick) mem_q[p_nick]   <= JOB_N5;
  end

  assign item_sol   = sol_q[2];
  assign coin5_sol  = sol_q[1];
  assign coin10_sol = sol_q[0];
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fault      = (state_q == S_FAULT);
  assign fault_job  = (state_q == S_FAULT) ? job_q : 2'b00;
  assign overflow   = ovf_q;
  assign q_count    = count_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: queued expected jobs, pulse monitor, reactive sensor model.
module tb_vend_dispense_ctrl;
  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 64;
  localparam int QD    = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic vend_in = 1'b0, change_5c_in = 1'b0, change_10c_in = 1'b0;
  logic item_sense = 1'b0, coin_sense = 1'b0, clear_fault = 1'b0;
  logic item_sol, coin5_sol, coin10_sol, busy, fault, overflow;
  logic [1:0] fault_job;
  logic [3:0] q_count;

  vend_dispense_ctrl #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .vend_in(vend_in), .change_5c_in(change_5c_in),
    .change_10c_in(change_10c_in), .item_sense(item_sense), .coin_sense(coin_sense),
    .clear_fault(clear_fault), .item_sol(item_sol), .coin5_sol(coin5_sol),
    .coin10_sol(coin10_sol), .busy(busy), .fault(fault), .fault_job(fault_job),
    .overflow(overflow), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int code; int req; } job_t;
  job_t exp_q[$];

  int checks = 0, errors = 0;
  int next_idle = 0, outstanding = 0, resp_mode = 0, fixed_d = 0;
  int n_rise = 0, rise_code = 0, rise_r = 0;
  event rise_ev;

  // monitor state
  bit         mon_in = 1'b0;
  int         mon_len, mon_code, mon_er;
  logic [2:0] mon_cur, mon_s;
  job_t       mon_e;
  // responder state
  int r_code, r_r, r_d, r_n, r_s;
  // stimulus scratch
  int pat, need, lim, nr0, fa, mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or timing off (cycle %0d)", name, cyc);
  endtask

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push_job(input int code, input int req);
    job_t j;
    j.code = code;
    j.req  = req;
    exp_q.push_back(j);
    outstanding++;
  endtask

  // Drive one cycle of requests; when acc is set, all given requests are expected to be queued.
  task automatic req_cycle(input bit v, input bit d, input bit n, input bit acc);
    @(posedge clk); #1;
    vend_in = v; change_10c_in = d; change_5c_in = n;
    if (acc) begin
      if (v) push_job(1, cyc);
      if (d) push_job(3, cyc);
      if (n) push_job(2, cyc);
    end
  endtask

  task automatic wait_until(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
    if (cyc != n) fail("wait_align");
  endtask

  task automatic wait_rise(input int base, input string tag);
    int l;
    l = 0;
    while (n_rise == base && l < 500) begin @(negedge clk); #1; l++; end
    if (n_rise == base) fail(tag);
  endtask

  task automatic drain(input string tag);
    int l;
    l = 0;
    while (outstanding != 0 && l < 3000) begin @(negedge clk); l++; end
    if (outstanding != 0) fail({tag, "_drain"});
    else begin
      wait_until(next_idle - 1);
      chk({tag, "_busy_before_idle"}, busy, 1);
      @(negedge clk);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_qcount_idle"}, q_count, 0);
      chk({tag, "_fault_idle"}, fault, 0);
      chk({tag, "_sols_idle"}, {item_sol, coin5_sol, coin10_sol}, 0);
    end
  endtask

  task automatic do_clear();
    resp_mode = 0;
    @(posedge clk); #1;
    clear_fault = 1'b1;
    next_idle = cyc + 1;
    outstanding--;
    @(posedge clk); #1;
    clear_fault = 1'b0;
    @(negedge clk);
    chk("fault_cleared", fault, 0);
    chk("fault_job_cleared", fault_job, 0);
  endtask

  task automatic set_sense(input int code, input bit right, input bit wrong);
    if (code == 1) begin item_sense = right; coin_sense = wrong; end
    else begin coin_sense = right; item_sense = wrong; end
  endtask

  // Monitor: every solenoid pulse must match the oldest expected job, start on time and last PULSE cycles.
  initial begin
    forever begin
      @(negedge clk);
      mon_s = {item_sol, coin5_sol, coin10_sol};
      if (rst) mon_in = 1'b0;
      else if (!mon_in) begin
        if (mon_s != 3'b000) begin
          mon_in  = 1'b1;
          mon_len = 1;
          mon_cur = mon_s;
          chk("sol_onehot", $countones(mon_s), 1);
          mon_code = mon_s[2] ? 1 : (mon_s[1] ? 2 : 3);
          if (exp_q.size() == 0) fail("unexpected_pulse");
          else begin
            mon_e  = exp_q.pop_front();
            mon_er = mx(next_idle, mon_e.req + 1) + 1;
            chk("pulse_job", mon_code, mon_e.code);
            chk("pulse_start", cyc, mon_er);
            rise_code = mon_e.code;
            rise_r    = mon_er;
            n_rise++;
            -> rise_ev;
          end
        end
      end else if (mon_s == mon_cur) mon_len++;
      else begin
        chk("pulse_len", mon_len, PULSE);
        chk("sol_after_pulse", mon_s, 0);
        mon_in = 1'b0;
      end
    end
  end

  // Mechanism model: confirms each pulse after a delay, with wrong-sensor noise beforehand.
  initial begin
    forever begin
      @(rise_ev);
      if (resp_mode == 0) begin
        r_code = rise_code;
        r_r    = rise_r;
        r_d    = (fixed_d != 0) ? fixed_d : $urandom_range(12, 1);
        r_n    = $urandom_range(r_d - 1, 0);
        for (int k = 1; k <= r_d; k++) begin
          @(posedge clk); #1;
          set_sense(r_code, k == r_d, (r_n != 0) && (k == r_n));
        end
        r_s = cyc;
        next_idle = ((r_s < r_r + PULSE) ? (r_r + PULSE) : (r_s + 1)) + GAP;
        outstanding--;
        @(posedge clk); #1;
        set_sense(r_code, $urandom_range(1, 0) == 1, 1'b0);
        @(posedge clk); #1;
        item_sense = 1'b0;
        coin_sense = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_item_sol", item_sol, 0);
    chk("rst_coin5_sol", coin5_sol, 0);
    chk("rst_coin10_sol", coin10_sol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_job", fault_job, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_q_count", q_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    next_idle = cyc;

    // single vend, confirmation arrives in WAIT
    fixed_d = 5;
    req_cycle(1, 0, 0, 1); req_cycle(0, 0, 0, 0);
    drain("t1");

    // vend + dime together, prompt confirmation during FIRE
    fixed_d = 2;
    req_cycle(1, 1, 0, 1); req_cycle(0, 0, 0, 0);
    drain("t2");

    // two dimes back to back while an item job is in flight
    fixed_d = 8;
    req_cycle(1, 0, 0, 1); req_cycle(0, 0, 0, 0);
    req_cycle(0, 1, 0, 1); req_cycle(0, 1, 0, 1); req_cycle(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_q_peak", q_count, 2);
    drain("t3");

    // random bursts within queue capacity
    fixed_d = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(5, 0)) @(posedge clk);
      pat  = $urandom_range(7, 1);
      need = $countones(pat[2:0]);
      lim  = 0;
      while (outstanding + need > QD && lim < 2000) begin @(negedge clk); lim++; end
      if (lim >= 2000) fail("rand_room");
      req_cycle(pat[2], pat[1], pat[0], 1); req_cycle(0, 0, 0, 0);
    end
    drain("rand");

    // nickel never confirmed -> fault; queued vend runs after clear
    resp_mode = 1;
    nr0 = n_rise;
    req_cycle(0, 0, 1, 1); req_cycle(1, 0, 0, 1); req_cycle(0, 0, 0, 0);
    wait_rise(nr0, "t4_rise");
    fa = rise_r + PULSE + TMO;
    wait_until(fa - 1);
    chk("t4_fault_early", fault, 0);
    @(negedge clk);
    chk("t4_fault", fault, 1);
    chk("t4_fault_job", fault_job, 2);
    chk("t4_busy", busy, 1);
    chk("t4_q_count", q_count, 1);
    chk("t4_sols_off", {item_sol, coin5_sol, coin10_sol}, 0);
    @(posedge clk); #1; coin_sense = 1'b1;
    @(posedge clk); #1; coin_sense = 1'b0;
    @(negedge clk);
    chk("t4_fault_hold", fault, 1);
    chk("t4_fault_job_hold", fault_job, 2);
    do_clear();
    drain("t4");

    // fill the queue while faulted, then overflow
    resp_mode = 1;
    nr0 = n_rise;
    req_cycle(0, 0, 1, 1); req_cycle(0, 0, 0, 0);
    wait_rise(nr0, "t5_rise");
    fa = rise_r + PULSE + TMO;
    wait_until(fa);
    chk("t5_fault", fault, 1);
    mcount = 0;
    for (int i = 0; i < QD; i++) begin
      req_cycle(0, 0, 1, mcount < QD);
      mcount++;
    end
    req_cycle(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_q_full", q_count, QD);
    chk("t5_no_ovf_yet", overflow, 0);
    req_cycle(0, 0, 1, 0); req_cycle(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_q_sat", q_count, QD);
    chk("t5_ovf", overflow, 1);
    req_cycle(1, 1, 0, 0); req_cycle(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_q_sat2", q_count, QD);
    chk("t5_ovf2", overflow, 1);
    chk("t5_fault_job", fault_job, 2);
    do_clear();
    drain("t5");
    chk("t5_ovf_sticky", overflow, 1);

    // reset in the second FIRE cycle with three jobs behind it
    resp_mode = 1;
    nr0 = n_rise;
    req_cycle(1, 0, 0, 1); req_cycle(1, 1, 1, 1); req_cycle(0, 0, 0, 0);
    wait_rise(nr0, "t6_rise");
    chk("t6_q_three", q_count, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    next_idle = cyc;
    exp_q.delete();
    outstanding = 0;
    @(negedge clk);
    chk("t6_item_sol", item_sol, 0);
    chk("t6_q_count", q_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_fault", fault, 0);

    // normal operation after reset
    resp_mode = 0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      pat = $urandom_range(7, 1);
      need = $countones(pat[2:0]);
      lim = 0;
      while (outstanding + need > QD && lim < 2000) begin @(negedge clk); lim++; end
      if (lim >= 2000) fail("post_rst_room");
      req_cycle(pat[2], pat[1], pat[0], 1); req_cycle(0, 0, 0, 0);
    end
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
